// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  localparam int DATA_W         = 32;
  localparam int NUM_LINES_DEF  = 64;
  localparam int LINE_WORDS_DEF = 4;
  localparam int OFF_W          = $clog2(LINE_WORDS_DEF);
  localparam int IDX_W          = $clog2(NUM_LINES_DEF);
  localparam int TAG_W          = 32 - OFF_W - IDX_W - 2;

  // Callers truncate the results to their own field widths.
  function automatic logic [31:0] addr_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int off_w = OFF_W);
    return a >> (off_w + 2);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w = OFF_W,
                                           input int idx_w = IDX_W);
    return a >> (off_w + idx_w + 2);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a, input int off_w = OFF_W);
    return a & ~((32'd1 << (off_w + 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Line data storage: NUM_LINES x LINE_WORDS words, asynchronous read, one synchronous write port.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int DW         = DATA_W
) (
  input  logic                          clock,
  input  logic                          we,
  input  logic [$clog2(NUM_LINES)-1:0]  w_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] w_word,
  input  logic [DW-1:0]                 w_data,
  input  logic [$clog2(NUM_LINES)-1:0]  r_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] r_word,
  output logic [DW-1:0]                 r_data
);

  logic [DW-1:0] mem [NUM_LINES*LINE_WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[{w_idx, w_word}] <= w_data;
  end

  assign r_data = mem[{r_idx, r_word}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational hit path, whole-line refill FSM on a miss.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  output logic [31:0] out,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] miss_count
);

  localparam int W_OFF = $clog2(LINE_WORDS);
  localparam int W_IDX = $clog2(NUM_LINES);
  localparam int W_TAG = 32 - W_OFF - W_IDX - 2;
  localparam logic [W_OFF-1:0] LAST_BEAT = W_OFF'(LINE_WORDS - 1);

  state_t             state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [W_TAG-1:0]   tag_ram [NUM_LINES];
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;
  logic [W_OFF-1:0]   beat_q;
  logic               flush_pend_q;
  logic [31:0]        miss_count_q;

  logic [W_OFF-1:0]   word;
  logic [W_IDX-1:0]   idx;
  logic [W_TAG-1:0]   tag;
  logic [W_IDX-1:0]   lidx;
  logic [W_TAG-1:0]   ltag;
  logic [31:0]        rd_data;
  logic               hit;
  logic               ram_we;

  assign word = W_OFF'(addr_word(addr));
  assign idx  = W_IDX'(addr_index(addr, W_OFF));
  assign tag  = W_TAG'(addr_tag(addr, W_OFF, W_IDX));
  assign lidx = W_IDX'(addr_index(mem_addr_q, W_OFF));
  assign ltag = W_TAG'(addr_tag(mem_addr_q, W_OFF, W_IDX));

  assign hit   = (state_q == IDLE) && valid_q[idx] && (tag_ram[idx] == tag) && !reset;
  assign stall = !hit;
  assign out   = hit ? rd_data : 32'h0;

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign miss_count = miss_count_q;

  assign ram_we = (state_q == FILL) && mem_rvalid && !reset;

  icache_data_ram #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .DW         (32)
  ) u_data_ram (
    .clock  (clock),
    .we     (ram_we),
    .w_idx  (lidx),
    .w_word (beat_q),
    .w_data (mem_rdata),
    .r_idx  (idx),
    .r_word (word),
    .r_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (!reset && state_q == DONE) tag_ram[lidx] <= ltag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      miss_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) valid_q <= '0;
          // Clearing the index here keeps a half-written line from ever hitting.
          if (!hit) begin
            mem_addr_q   <= line_base(addr, W_OFF);
            mem_req_q    <= 1'b1;
            valid_q[idx] <= 1'b0;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= FILL;
          end
        end
        FILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) state_q <= DONE;
          end
        end
        DONE: begin
          // A flush seen during the refill also invalidates the line just written.
          if (flush_pend_q || flush) valid_q <= '0;
          else                       valid_q[lidx] <= 1'b1;
          flush_pend_q <= 1'b0;
          miss_count_q <= miss_count_q + 32'd1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
